// File: rtl/fft16_pkg.sv
// Shared constants and state encoding for the 16-point FFT stream adapter.
// Contents:
//   N, DATA_W, GAIN_W, OUT_W, CNT_W  frame and sample geometry
//   FILL/START/WAIT/DRAIN            adapter state encoding
//   MODE_FFT/MODE_IFFT               core transform direction
package fft16_pkg;

  localparam int N      = 16;
  localparam int DATA_W = 12;
  localparam int GAIN_W = 4;
  localparam int OUT_W  = DATA_W + GAIN_W;
  localparam int CNT_W  = $clog2(N);

  typedef logic [1:0] state_t;

  localparam state_t FILL  = 2'd0;
  localparam state_t START = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t DRAIN = 2'd3;

  localparam logic MODE_FFT  = 1'b0;
  localparam logic MODE_IFFT = 1'b1;

endpackage

// File: rtl/fft16_frame_buf.sv
// N-entry complex register bank, element k packed at [k*W +: W].
// Ports:
//   clk, rst_n          clock, async active-low reset (clears every entry)
//   we, widx            write one entry
//   wr_real, wr_imag    data for the indexed write
//   pad                 with we: also zero every entry above widx
//   load                parallel load of all entries from ld_real/ld_imag
//   ld_real, ld_imag    flattened parallel load data
//   rd_real, rd_imag    flattened parallel read
module fft16_frame_buf
  import fft16_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             pad,
  input  logic [CNT_W-1:0] widx,
  input  logic [W-1:0]     wr_real,
  input  logic [W-1:0]     wr_imag,
  input  logic             load,
  input  logic [N*W-1:0]   ld_real,
  input  logic [N*W-1:0]   ld_imag,
  output logic [N*W-1:0]   rd_real,
  output logic [N*W-1:0]   rd_imag
);

  logic [W-1:0] re_q [N];
  logic [W-1:0] im_q [N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N; k++) begin
        re_q[k] <= '0;
        im_q[k] <= '0;
      end
    end else if (load) begin
      for (int k = 0; k < N; k++) begin
        re_q[k] <= ld_real[k*W +: W];
        im_q[k] <= ld_imag[k*W +: W];
      end
    end else if (we) begin
      for (int k = 0; k < N; k++) begin
        if (CNT_W'(k) == widx) begin
          re_q[k] <= wr_real;
          im_q[k] <= wr_imag;
        end else if (pad && (CNT_W'(k) > widx)) begin
          re_q[k] <= '0;
          im_q[k] <= '0;
        end
      end
    end
  end

  always_comb begin
    rd_real = '0;
    rd_imag = '0;
    for (int k = 0; k < N; k++) begin
      rd_real[k*W +: W] = re_q[k];
      rd_imag[k*W +: W] = im_q[k];
    end
  end

endmodule

// File: rtl/fft16_stream_adapter.sv
// Stream front/back end for the 16-point FFT/IFFT core: gathers a frame from
// the s_* stream, launches the core, captures its result and replays it on
// the m_* stream. Frames do not overlap.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   s_valid/s_ready/s_real/s_imag   input sample stream
//   s_mode, s_last                  frame mode (sample 0), frame end marker
//   m_valid/m_ready/m_real/m_imag   output bin stream, m_last on bin 15
//   core_start, core_mode           core launch pulse and frame mode
//   core_real_in, core_imag_in      flattened input frame to the core
//   core_real_out, core_imag_out    flattened core result
//   core_done                       core result valid (level)
//   busy, err_len                   not-in-FILL flag, frame length error pulse
//
// state | meaning
// FILL  | accepting samples into the frame buffer
// START | one-cycle core_start pulse
// WAIT  | frame held on core inputs until core_done
// DRAIN | replaying captured bins downstream
module fft16_stream_adapter
  import fft16_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [DATA_W-1:0]  s_real,
  input  logic [DATA_W-1:0]  s_imag,
  input  logic               s_mode,
  input  logic               s_last,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [OUT_W-1:0]   m_real,
  output logic [OUT_W-1:0]   m_imag,
  output logic               m_last,
  output logic               core_start,
  output logic               core_mode,
  output logic [N*DATA_W-1:0] core_real_in,
  output logic [N*DATA_W-1:0] core_imag_in,
  input  logic [N*OUT_W-1:0] core_real_out,
  input  logic [N*OUT_W-1:0] core_imag_out,
  input  logic               core_done,
  output logic               busy,
  output logic               err_len
);

  state_t           state;
  // Shared index: sample slot while filling, bin number while draining.
  logic [CNT_W-1:0] cnt;
  logic             s_hs, m_hs, at_end, closing, cap_load;
  logic [N*OUT_W-1:0] cap_real, cap_imag;

  assign s_ready    = (state == FILL);
  assign busy       = (state != FILL);
  assign core_start = (state == START);
  assign m_valid    = (state == DRAIN);
  assign m_last     = m_valid && at_end;

  assign at_end   = (cnt == CNT_W'(N-1));
  assign s_hs     = s_valid && s_ready;
  assign m_hs     = m_valid && m_ready;
  assign closing  = s_hs && (s_last || at_end);
  assign cap_load = (state == WAIT) && core_done;

  always_comb begin
    m_real = cap_real[int'(cnt)*OUT_W +: OUT_W];
    m_imag = cap_imag[int'(cnt)*OUT_W +: OUT_W];
  end

  // An early s_last zero-pads the slots above it in the same write.
  fft16_frame_buf #(.W(DATA_W)) u_in_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (s_hs),
    .pad     (s_last),
    .widx    (cnt),
    .wr_real (s_real),
    .wr_imag (s_imag),
    .load    (1'b0),
    .ld_real ('0),
    .ld_imag ('0),
    .rd_real (core_real_in),
    .rd_imag (core_imag_in)
  );

  fft16_frame_buf #(.W(OUT_W)) u_cap_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (1'b0),
    .pad     (1'b0),
    .widx    ('0),
    .wr_real ('0),
    .wr_imag ('0),
    .load    (cap_load),
    .ld_real (core_real_out),
    .ld_imag (core_imag_out),
    .rd_real (cap_real),
    .rd_imag (cap_imag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      cnt       <= '0;
      core_mode <= MODE_FFT;
      err_len   <= 1'b0;
    end else begin
      err_len <= 1'b0;
      case (state)
        FILL: begin
          if (s_hs) begin
            if (cnt == '0) core_mode <= (s_mode == MODE_IFFT);
            if (closing) begin
              state   <= START;
              cnt     <= '0;
              // Only a last flag exactly on slot 15 is a well-formed frame.
              err_len <= !(s_last && at_end);
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (core_done) state <= DRAIN;
        end
        DRAIN: begin
          if (m_hs) begin
            if (at_end) begin
              state <= FILL;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fft16_stream_adapter.sv
module tb_fft16_stream_adapter;
  import fft16_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic s_valid, s_ready, s_mode, s_last;
  logic [DATA_W-1:0] s_real, s_imag;
  logic m_valid, m_ready, m_last;
  logic [OUT_W-1:0] m_real, m_imag;
  logic core_start, core_mode, core_done, busy, err_len;
  logic [N*DATA_W-1:0] core_real_in, core_imag_in;
  logic [N*OUT_W-1:0]  core_real_out, core_imag_out;

  always #5 clk = ~clk;

  fft16_stream_adapter dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real), .s_imag(s_imag),
    .s_mode(s_mode), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real), .m_imag(m_imag),
    .m_last(m_last),
    .core_start(core_start), .core_mode(core_mode),
    .core_real_in(core_real_in), .core_imag_in(core_imag_in),
    .core_real_out(core_real_out), .core_imag_out(core_imag_out),
    .core_done(core_done), .busy(busy), .err_len(err_len)
  );

  // Core stub: result is the sign-extended input, done rises 20 cycles after start.
  for (genvar k = 0; k < N; k++) begin : g_stub
    assign core_real_out[k*OUT_W +: OUT_W] =
      {{GAIN_W{core_real_in[k*DATA_W+DATA_W-1]}}, core_real_in[k*DATA_W +: DATA_W]};
    assign core_imag_out[k*OUT_W +: OUT_W] =
      {{GAIN_W{core_imag_in[k*DATA_W+DATA_W-1]}}, core_imag_in[k*DATA_W +: DATA_W]};
  end

  int stub_tmr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      stub_tmr  <= 0;
    end else if (core_start) begin
      core_done <= 1'b0;
      stub_tmr  <= 20;
    end else if (stub_tmr != 0) begin
      stub_tmr <= stub_tmr - 1;
      if (stub_tmr == 1) core_done <= 1'b1;
    end
  end

  typedef struct packed {
    logic [OUT_W-1:0] re;
    logic [OUT_W-1:0] im;
    logic             last;
  } beat_t;

  beat_t exp_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int n_start = 0;
  int n_err = 0;
  int hs_cnt = 0;
  logic exp_mode = 1'b0;
  logic tog_en = 1'b0;
  int vr[N];
  int vi[N];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (core_start) n_start++;
      if (err_len) n_err++;
    end
  end

  // Output monitor: scoreboard pop, stall-hold, s_ready exclusion.
  logic held_v = 1'b0;
  logic after_last = 1'b0;
  logic [OUT_W-1:0] held_re, held_im;
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      held_v     = 1'b0;
      after_last = 1'b0;
    end else begin
      if (after_last) begin
        check("s_ready_after_last", 64'(s_ready), 64'd1);
        after_last = 1'b0;
      end
      if (m_valid) check("s_ready_low_in_drain", 64'(s_ready), 64'd0);
      if (held_v && m_valid) begin
        check("hold_real", 64'(m_real), 64'(held_re));
        check("hold_imag", 64'(m_imag), 64'(held_im));
      end
      held_v  = m_valid && !m_ready;
      held_re = m_real;
      held_im = m_imag;
      if (m_valid && m_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_beat: got %0h/%0h with no expected beat", m_real, m_imag);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_real, m_imag, m_last}), 64'(e));
          check("beat_mode", 64'(core_mode), 64'(exp_mode));
        end
        if (m_last) after_last = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (tog_en) begin
      #1 m_ready = ~m_ready;
    end
  end

  task automatic run_frame(input int len, input bit last_final, input bit mode, input bit push);
    beat_t b;
    bit exp_err;
    int t;
    exp_err = !(len == N && last_final);
    if (push) begin
      exp_mode = mode;
      for (int k = 0; k < N; k++) begin
        b.re   = (k < len) ? OUT_W'(vr[k]) : '0;
        b.im   = (k < len) ? OUT_W'(vi[k]) : '0;
        b.last = (k == N-1);
        exp_q.push_back(b);
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < len; k++) begin
      s_valid = 1'b1;
      s_real  = DATA_W'(vr[k]);
      s_imag  = DATA_W'(vi[k]);
      s_mode  = (k == 0) ? mode : ~mode;
      s_last  = (k == len-1) ? ((len < N) || last_final) : 1'b0;
      t = 0;
      while (1) begin
        @(negedge clk);
        if (s_ready) break;
        t++;
        if (t > 200) begin
          check("s_ready_timeout", 64'(s_ready), 64'd1);
          break;
        end
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    @(negedge clk);
    check("core_start_latency", 64'(core_start), 64'd1);
    check("err_len", 64'(err_len), 64'(exp_err));
    check("core_mode_latched", 64'(core_mode), 64'(mode));
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 1000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 1000) check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  int s0, e0;
  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_real = '0; s_imag = '0;
    s_mode = 1'b0; s_last = 1'b0; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_last", 64'(m_last), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_core_start", 64'(core_start), 64'd0);
    check("rst_err_len", 64'(err_len), 64'd0);
    check("rst_core_mode", 64'(core_mode), 64'd0);
    check("rst_frame", 64'(|core_real_in | |core_imag_in), 64'd0);

    // Frame 1: (k, -k), FFT mode
    for (int k = 0; k < N; k++) begin vr[k] = k; vi[k] = -k; end
    s0 = n_start; e0 = n_err; hs_cnt = 0;
    run_frame(N, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("f1_starts", 64'(n_start - s0), 64'd1);
    check("f1_errs", 64'(n_err - e0), 64'd0);
    check("f1_beats", 64'(hs_cnt), 64'd16);

    // Frame 2: IFFT on sample 0 only, mode must stay latched through WAIT
    for (int k = 0; k < N; k++) begin vr[k] = k*37 - 300; vi[k] = 1000 - k*111; end
    s0 = n_start; hs_cnt = 0;
    run_frame(N, 1'b1, 1'b1, 1'b1);
    repeat (10) @(negedge clk);
    check("f2_mode_in_wait", 64'(core_mode), 64'd1);
    wait_idle();
    check("f2_starts", 64'(n_start - s0), 64'd1);
    check("f2_beats", 64'(hs_cnt), 64'd16);

    // Frame 3: early last on sample 3, remaining bins zero-padded
    vr[0] = 100;   vi[0] = 0;
    vr[1] = -2048; vi[1] = 2047;
    vr[2] = 5;     vi[2] = 5;
    vr[3] = 7;     vi[3] = -7;
    e0 = n_err; hs_cnt = 0;
    run_frame(4, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("f3_errs", 64'(n_err - e0), 64'd1);
    check("f3_beats", 64'(hs_cnt), 64'd16);

    // Frame 4: no last flag on sample 15
    for (int k = 0; k < N; k++) begin vr[k] = k*100 - 800; vi[k] = 3*k; end
    e0 = n_err; hs_cnt = 0;
    run_frame(N, 1'b0, 1'b0, 1'b1);
    wait_idle();
    check("f4_errs", 64'(n_err - e0), 64'd1);
    check("f4_beats", 64'(hs_cnt), 64'd16);

    // Frame 5: downstream stalls every other cycle
    for (int k = 0; k < N; k++) begin vr[k] = 2047 - k*200; vi[k] = -2048 + k*150; end
    hs_cnt = 0;
    tog_en = 1'b1;
    run_frame(N, 1'b1, 1'b1, 1'b1);
    wait_idle();
    tog_en = 1'b0;
    @(posedge clk); #2 m_ready = 1'b1;
    check("f5_beats", 64'(hs_cnt), 64'd16);

    // Frame 6: reset while waiting for the core; nothing may emerge
    for (int k = 0; k < N; k++) begin vr[k] = 11*k; vi[k] = -5*k; end
    hs_cnt = 0;
    run_frame(N, 1'b1, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("f6_s_ready", 64'(s_ready), 64'd1);
    check("f6_busy", 64'(busy), 64'd0);
    repeat (40) @(negedge clk);
    check("f6_no_beats", 64'(hs_cnt), 64'd0);

    // Frame 7: full frame after the abort
    for (int k = 0; k < N; k++) begin vr[k] = 500 - 63*k; vi[k] = 17*k - 99; end
    s0 = n_start; hs_cnt = 0;
    run_frame(N, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("f7_starts", 64'(n_start - s0), 64'd1);
    check("f7_beats", 64'(hs_cnt), 64'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
